// File: rtl/alu_pipe_pkg.sv
// Opcode and FSM encodings plus decode helpers shared by the execute-stage ALU.
package alu_pkg;

  typedef enum logic [5:0] {
    OP_ADD  = 6'h00,
    OP_ADDI = 6'h01,
    OP_SUB  = 6'h02,
    OP_SUBI = 6'h03,
    OP_MUL  = 6'h04,
    OP_MULI = 6'h05,
    OP_OR   = 6'h06,
    OP_ORI  = 6'h07,
    OP_AND  = 6'h08,
    OP_ANDI = 6'h09,
    OP_XOR  = 6'h0A,
    OP_XORI = 6'h0B,
    OP_LDW  = 6'h0C,
    OP_STW  = 6'h0D,
    OP_BZ   = 6'h0E,
    OP_BEQ  = 6'h0F,
    OP_JR   = 6'h10
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_HOLD
  } state_e;

  function automatic logic is_mem_op(input logic [5:0] op);
    is_mem_op = (op == OP_LDW) || (op == OP_STW);
  endfunction

  // Address generation shares the adder, so LDW/STW also take the immediate.
  function automatic logic is_imm_op(input logic [5:0] op);
    case (op)
      OP_ADDI, OP_SUBI, OP_MULI, OP_ORI, OP_ANDI, OP_XORI, OP_LDW, OP_STW: is_imm_op = 1'b1;
      default: is_imm_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Decode-side request and MEM-side result bundle for the execute-stage ALU.
interface alu_pipe_if #(parameter int DATA_W = 32);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        op;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] pc4;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_is_mem;
  logic              br_taken;
  logic [DATA_W-1:0] br_target;
  logic              ovf;
  logic              illegal;

  modport master (
    output flush, in_valid, op, rs_val, rt_val, imm, pc4, out_ready,
    input  in_ready, out_valid, out_result, out_is_mem, br_taken, br_target, ovf, illegal
  );

  modport slave (
    input  flush, in_valid, op, rs_val, rt_val, imm, pc4, out_ready,
    output in_ready, out_valid, out_result, out_is_mem, br_taken, br_target, ovf, illegal
  );
endinterface

// File: rtl/alu_pipe_mul.sv
// Iterative signed multiplier: radix-2^MUL_STEP shift-add on operand magnitudes,
// with the sign applied to the final sum.
module alu_mul_iter #(
  parameter int DATA_W   = 32,
  parameter int MUL_STEP = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_kill,
  input  logic                i_start,
  input  logic [DATA_W-1:0]   i_a,
  input  logic [DATA_W-1:0]   i_b,
  output logic                o_done,
  output logic [2*DATA_W-1:0] o_product
);
  localparam int STEPS = DATA_W / MUL_STEP;
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam int PW    = 2 * DATA_W;

  logic              r_busy;
  logic              r_neg;
  logic [CNT_W-1:0]  r_cnt;
  logic [PW-1:0]     r_mcand;
  logic [PW-1:0]     r_acc;
  logic [DATA_W-1:0] r_mplier;

  logic [DATA_W-1:0] w_absA;
  logic [DATA_W-1:0] w_absB;
  logic [PW-1:0]     w_partial;
  logic [PW-1:0]     w_sum;
  logic [PW-1:0]     w_mag;

  assign w_absA    = i_a[DATA_W-1] ? (~i_a + DATA_W'(1)) : i_a;
  assign w_absB    = i_b[DATA_W-1] ? (~i_b + DATA_W'(1)) : i_b;
  assign w_partial = r_mcand * PW'(r_mplier[MUL_STEP-1:0]);
  assign w_sum     = r_acc + w_partial;

  // The final step is forwarded combinationally; afterwards the accumulator holds it.
  assign w_mag     = r_busy ? w_sum : r_acc;
  assign o_product = r_neg ? (~w_mag + PW'(1)) : w_mag;
  assign o_done    = r_busy && (r_cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
    end else if (i_kill) begin
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_neg    <= i_a[DATA_W-1] ^ i_b[DATA_W-1];
      r_cnt    <= CNT_W'(STEPS);
      r_mcand  <= PW'(w_absA);
      r_mplier <= w_absB;
      r_acc    <= '0;
    end else if (r_busy) begin
      r_acc    <= w_sum;
      r_mcand  <= r_mcand << MUL_STEP;
      r_mplier <= r_mplier >> MUL_STEP;
      r_cnt    <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) r_busy <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_pipe.sv
// Handshaked execute-stage ALU: single-cycle ops, address generation, branch
// resolution and an iterative signed multiplier behind a registered output.
module alu_pipe import alu_pkg::*; #(
  parameter int DATA_W   = 32,
  parameter int MUL_STEP = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_pipe_if.slave bus
);
  localparam int MSB = DATA_W - 1;

  state_e            r_state;
  logic              r_outValid;
  logic              r_isMem;
  logic              r_brTaken;
  logic              r_ovf;
  logic              r_illegal;
  logic [DATA_W-1:0] r_result;
  logic [DATA_W-1:0] r_brTarget;
  logic [DATA_W-1:0] r_mulPc4;

  logic                w_outFree;
  logic                w_accept;
  logic                w_isMul;
  logic                w_mulDone;
  logic                w_mulLoad;
  logic                w_mulOvf;
  logic [2*DATA_W-1:0] w_product;
  logic [DATA_W-1:0]   w_opB;
  logic [DATA_W-1:0]   w_sum;
  logic [DATA_W-1:0]   w_diff;
  logic [DATA_W-1:0]   w_result;
  logic [DATA_W-1:0]   w_target;
  logic                w_ovf;
  logic                w_isMem;
  logic                w_taken;
  logic                w_illegal;

  assign w_outFree    = !r_outValid || bus.out_ready;
  assign bus.in_ready = rst_n && (r_state == ST_IDLE) && w_outFree && !bus.flush;
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_isMul      = (bus.op == OP_MUL) || (bus.op == OP_MULI);
  assign w_opB        = is_imm_op(bus.op) ? bus.imm : bus.rt_val;
  assign w_sum        = bus.rs_val + w_opB;
  assign w_diff       = bus.rs_val - w_opB;

  // Product fits in DATA_W signed bits only if the upper half repeats the result sign.
  assign w_mulOvf  = !((&w_product[2*DATA_W-1:MSB]) || !(|w_product[2*DATA_W-1:MSB]));
  assign w_mulLoad = w_outFree && (((r_state == ST_MUL) && w_mulDone) || (r_state == ST_HOLD));

  alu_mul_iter #(.DATA_W(DATA_W), .MUL_STEP(MUL_STEP)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_kill    (bus.flush),
    .i_start   (w_accept && w_isMul),
    .i_a       (bus.rs_val),
    .i_b       (w_opB),
    .o_done    (w_mulDone),
    .o_product (w_product)
  );

  always_comb begin
    w_result  = '0;
    w_ovf     = 1'b0;
    w_isMem   = is_mem_op(bus.op);
    w_taken   = 1'b0;
    w_target  = bus.pc4;
    w_illegal = 1'b0;
    case (bus.op)
      OP_ADD, OP_ADDI: begin
        w_result = w_sum;
        w_ovf    = (bus.rs_val[MSB] == w_opB[MSB]) && (w_sum[MSB] != bus.rs_val[MSB]);
      end
      OP_SUB, OP_SUBI: begin
        w_result = w_diff;
        w_ovf    = (bus.rs_val[MSB] != w_opB[MSB]) && (w_diff[MSB] != bus.rs_val[MSB]);
      end
      OP_OR,  OP_ORI:  w_result = bus.rs_val | w_opB;
      OP_AND, OP_ANDI: w_result = bus.rs_val & w_opB;
      OP_XOR, OP_XORI: w_result = bus.rs_val ^ w_opB;
      OP_LDW, OP_STW:  w_result = w_sum;
      OP_BZ:           w_taken  = (bus.rs_val == '0);
      OP_BEQ:          w_taken  = (bus.rs_val == bus.rt_val);
      OP_JR:           w_taken  = 1'b1;
      OP_MUL, OP_MULI: w_result = '0;
      default:         w_illegal = 1'b1;
    endcase
    if (w_taken) w_target = (bus.op == OP_JR) ? bus.rs_val : (bus.pc4 + bus.imm);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_outValid <= 1'b0;
      r_isMem    <= 1'b0;
      r_brTaken  <= 1'b0;
      r_ovf      <= 1'b0;
      r_illegal  <= 1'b0;
      r_result   <= '0;
      r_brTarget <= '0;
      r_mulPc4   <= '0;
    end else if (bus.flush) begin
      r_state    <= ST_IDLE;
      r_outValid <= 1'b0;
    end else begin
      if (r_outValid && bus.out_ready) r_outValid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept && w_isMul) begin
            r_state  <= ST_MUL;
            r_mulPc4 <= bus.pc4;
          end else if (w_accept) begin
            r_outValid <= 1'b1;
            r_result   <= w_result;
            r_ovf      <= w_ovf;
            r_isMem    <= w_isMem;
            r_brTaken  <= w_taken;
            r_brTarget <= w_target;
            r_illegal  <= w_illegal;
          end
        end
        ST_MUL:  if (w_mulDone) r_state <= w_outFree ? ST_IDLE : ST_HOLD;
        ST_HOLD: if (w_outFree) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
      if (w_mulLoad) begin
        r_outValid <= 1'b1;
        r_result   <= w_product[DATA_W-1:0];
        r_ovf      <= w_mulOvf;
        r_isMem    <= 1'b0;
        r_brTaken  <= 1'b0;
        r_brTarget <= r_mulPc4;
        r_illegal  <= 1'b0;
      end
    end
  end

  assign bus.out_valid  = r_outValid;
  assign bus.out_result = r_result;
  assign bus.out_is_mem = r_isMem;
  assign bus.br_taken   = r_brTaken;
  assign bus.br_target  = r_brTarget;
  assign bus.ovf        = r_ovf;
  assign bus.illegal    = r_illegal;
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed vector table, randomized ops against a behavioural
// model, and hand-written stall / flush / reset sequences.
`timescale 1ns/1ps
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int DATA_W   = 32;
  localparam int MUL_STEP = 2;
  localparam int MUL_LAT  = DATA_W / MUL_STEP + 1;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] rs, rt, imm, pc4;
    logic [31:0] result;
    logic        ovf, taken;
    logic [31:0] target;
    logic        isMem, illegal, chkRes;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   nChecks = 0;
  int   nFail = 0;

  always #5 clk = ~clk;

  alu_pipe_if #(.DATA_W(DATA_W)) bus ();

  alu_pipe #(.DATA_W(DATA_W), .MUL_STEP(MUL_STEP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic vec_t mk(input logic [5:0] op, input logic [31:0] rs, rt, imm, pc4,
                              input logic [31:0] result, input logic ovf, taken,
                              input logic [31:0] target, input logic isMem, illegal, chkRes,
                              input int lat);
    vec_t v;
    v.op = op; v.rs = rs; v.rt = rt; v.imm = imm; v.pc4 = pc4;
    v.result = result; v.ovf = ovf; v.taken = taken; v.target = target;
    v.isMem = isMem; v.illegal = illegal; v.chkRes = chkRes; v.lat = lat;
    return v;
  endfunction

  // Expected behaviour from plain signed arithmetic on 64-bit integers.
  function automatic vec_t refModel(input logic [5:0] op, input logic [31:0] rs, rt, imm, pc4);
    vec_t   v;
    longint a, b, full;
    logic [31:0] opB;
    logic [63:0] fullBits;
    opB = (op inside {6'h01, 6'h03, 6'h05, 6'h07, 6'h09, 6'h0B, 6'h0C, 6'h0D}) ? imm : rt;
    a = longint'($signed(rs));
    b = longint'($signed(opB));
    v = mk(op, rs, rt, imm, pc4, 32'h0, 1'b0, 1'b0, pc4, 1'b0, 1'b0, 1'b1, 1);
    full = 0;
    case (op)
      6'h00, 6'h01: full = a + b;
      6'h02, 6'h03: full = a - b;
      6'h04, 6'h05: begin full = a * b; v.lat = MUL_LAT; end
      default: full = 0;
    endcase
    fullBits = full;
    case (op)
      6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05: begin
        v.result = fullBits[31:0];
        v.ovf    = (full > SMAX) || (full < SMIN);
      end
      6'h06, 6'h07: v.result = rs | opB;
      6'h08, 6'h09: v.result = rs & opB;
      6'h0A, 6'h0B: v.result = rs ^ opB;
      6'h0C, 6'h0D: begin v.result = rs + imm; v.isMem = 1'b1; end
      6'h0E: begin v.chkRes = 1'b0; v.taken = (rs == 0);  if (v.taken) v.target = pc4 + imm; end
      6'h0F: begin v.chkRes = 1'b0; v.taken = (rs == rt); if (v.taken) v.target = pc4 + imm; end
      6'h10: begin v.chkRes = 1'b0; v.taken = 1'b1; v.target = rs; end
      default: v.illegal = 1'b1;
    endcase
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic driveOp(input vec_t v);
    bus.op = v.op; bus.rs_val = v.rs; bus.rt_val = v.rt; bus.imm = v.imm; bus.pc4 = v.pc4;
    bus.in_valid = 1'b1;
  endtask

  // Offers one op, waits (bounded) for accept, then counts edges until out_valid.
  task automatic applyStimulus(input vec_t v, output int lat, output bit sawReady);
    int guard;
    @(negedge clk);
    driveOp(v);
    #1;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk); #1; guard++;
    end
    if (guard >= 50) begin
      nChecks++; nFail++;
      $display("[TB] FAIL acceptTimeout: got in_ready 0, expected 1");
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    sawReady = 1'b0;
    while (!bus.out_valid && lat < 60) begin
      if (bus.in_ready) sawReady = 1'b1;
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic runVec(input vec_t v, input string tag);
    int lat;
    bit sawReady;
    applyStimulus(v, lat, sawReady);
    checkOutput($sformatf("%s.lat", tag), lat, v.lat);
    if (v.chkRes) checkOutput($sformatf("%s.result", tag), bus.out_result, v.result);
    checkOutput($sformatf("%s.ovf", tag), bus.ovf, v.ovf);
    checkOutput($sformatf("%s.taken", tag), bus.br_taken, v.taken);
    checkOutput($sformatf("%s.target", tag), bus.br_target, v.target);
    checkOutput($sformatf("%s.isMem", tag), bus.out_is_mem, v.isMem);
    checkOutput($sformatf("%s.illegal", tag), bus.illegal, v.illegal);
    if (v.lat > 1) checkOutput($sformatf("%s.inReadyDuringMul", tag), sawReady, 1'b0);
  endtask

  function automatic logic [31:0] pickVal();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic watchNoValid(input string tag, input int cycles);
    bit seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    checkOutput(tag, seen, 1'b0);
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;
    int   lat;
    logic [5:0]  rop;
    logic [31:0] rrs, rrt;

    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.op = '0; bus.rs_val = '0; bus.rt_val = '0; bus.imm = '0; bus.pc4 = '0;

    tbl.push_back(mk(OP_ADD,  32'h7FFFFFFF, 32'h1, 32'h0, 32'h100, 32'h80000000, 1, 0, 32'h100, 0, 0, 1, 1));
    tbl.push_back(mk(OP_SUBI, 32'h5, 32'h0, 32'hFFFFFFFD, 32'h100, 32'h8, 0, 0, 32'h100, 0, 0, 1, 1));
    tbl.push_back(mk(OP_SUB,  32'h80000000, 32'h1, 32'h0, 32'h104, 32'h7FFFFFFF, 1, 0, 32'h104, 0, 0, 1, 1));
    tbl.push_back(mk(OP_MUL,  32'hFFFFFFFA, 32'h7, 32'h0, 32'h108, 32'hFFFFFFD6, 0, 0, 32'h108, 0, 0, 1, 17));
    tbl.push_back(mk(OP_MUL,  32'h00010000, 32'h00010000, 32'h0, 32'h10C, 32'h0, 1, 0, 32'h10C, 0, 0, 1, 17));
    tbl.push_back(mk(OP_MULI, 32'hFFFFFFFF, 32'h0, 32'h80000000, 32'h110, 32'h80000000, 1, 0, 32'h110, 0, 0, 1, 17));
    tbl.push_back(mk(OP_MUL,  32'h80000000, 32'h80000000, 32'h0, 32'h114, 32'h0, 1, 0, 32'h114, 0, 0, 1, 17));
    tbl.push_back(mk(OP_AND,  32'hFF00FF00, 32'h0FF00FF0, 32'h0, 32'h118, 32'h0F000F00, 0, 0, 32'h118, 0, 0, 1, 1));
    tbl.push_back(mk(OP_XORI, 32'hF0F0F0F0, 32'h0, 32'hFFFFFFFF, 32'h11C, 32'h0F0F0F0F, 0, 0, 32'h11C, 0, 0, 1, 1));
    tbl.push_back(mk(OP_LDW,  32'h1000, 32'h0, 32'hFFFFFFFC, 32'h120, 32'h00000FFC, 0, 0, 32'h120, 1, 0, 1, 1));
    tbl.push_back(mk(OP_BEQ,  32'h9, 32'h9, 32'h10, 32'h100, 32'h0, 0, 1, 32'h110, 0, 0, 0, 1));
    tbl.push_back(mk(OP_BEQ,  32'h9, 32'h8, 32'h10, 32'h100, 32'h0, 0, 0, 32'h100, 0, 0, 0, 1));
    tbl.push_back(mk(OP_BZ,   32'h1, 32'h0, 32'h10, 32'h100, 32'h0, 0, 0, 32'h100, 0, 0, 0, 1));
    tbl.push_back(mk(OP_BZ,   32'h0, 32'h0, 32'hFFFFFFF0, 32'h200, 32'h0, 0, 1, 32'h1F0, 0, 0, 0, 1));
    tbl.push_back(mk(OP_JR,   32'h400, 32'h0, 32'h0, 32'h100, 32'h0, 0, 1, 32'h400, 0, 0, 0, 1));
    tbl.push_back(mk(6'h3F,   32'h1234, 32'h5678, 32'h0, 32'h124, 32'h0, 0, 0, 32'h124, 0, 1, 1, 1));

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst.outValid", bus.out_valid, 1'b0);
    checkOutput("rst.result", bus.out_result, 32'h0);
    checkOutput("rst.target", bus.br_target, 32'h0);
    checkOutput("rst.flags", {bus.ovf, bus.illegal, bus.br_taken, bus.out_is_mem}, 4'h0);
    checkOutput("rst.inReadyLow", bus.in_ready, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("rst.inReadyHigh", bus.in_ready, 1'b1);

    foreach (tbl[i]) runVec(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 150; i++) begin
      rop = ($urandom_range(0, 17) == 17) ? 6'($urandom_range(17, 63)) : 6'($urandom_range(0, 16));
      rrs = pickVal();
      rrt = ($urandom_range(0, 3) == 0) ? rrs : pickVal();
      v = refModel(rop, rrs, rrt, pickVal(), $urandom);
      runVec(v, $sformatf("rand%0d_op%02h", i, rop));
    end

    // Output stall on LDW, then a MUL accepted on the drain cycle and held under stall
    repeat (2) @(negedge clk);
    bus.out_ready = 1'b0;
    driveOp(mk(OP_LDW, 32'h1000, 32'h0, 32'hFFFFFFFC, 32'h500, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("stall.outValid", bus.out_valid, 1'b1);
      checkOutput("stall.result", bus.out_result, 32'h00000FFC);
      checkOutput("stall.isMem", bus.out_is_mem, 1'b1);
      checkOutput("stall.inReady", bus.in_ready, 1'b0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    driveOp(mk(OP_MUL, 32'h3, 32'hFFFFFFFB, 32'h0, 32'h504, 0, 0, 0, 0, 0, 0, 0, 0));
    #1 checkOutput("drain.inReady", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    checkOutput("drain.outValidDrops", bus.out_valid, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
    checkOutput("stallMul.lat", lat, MUL_LAT);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checkOutput("stallMul.outValid", bus.out_valid, 1'b1);
      checkOutput("stallMul.result", bus.out_result, 32'hFFFFFFF1);
      checkOutput("stallMul.target", bus.br_target, 32'h504);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("stallMul.dropAfterDrain", bus.out_valid, 1'b0);

    // Flush blocks an accept attempted in the same cycle
    repeat (2) @(negedge clk);
    driveOp(mk(OP_ADD, 32'h1, 32'h1, 32'h0, 32'h600, 0, 0, 0, 0, 0, 0, 0, 0));
    bus.flush = 1'b1;
    #1 checkOutput("flushIdle.inReady", bus.in_ready, 1'b0);
    @(posedge clk); #1;
    checkOutput("flushIdle.outValid", bus.out_valid, 1'b0);
    @(negedge clk);
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;

    // Flush in the third multiply cycle kills the op
    @(negedge clk);
    driveOp(mk(OP_MUL, 32'h6, 32'h7, 32'h0, 32'h604, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    checkOutput("flushMul.inReady", bus.in_ready, 1'b1);
    checkOutput("flushMul.outValid", bus.out_valid, 1'b0);
    watchNoValid("flushMul.neverValid", 25);
    runVec(mk(OP_ADD, 32'h2, 32'h3, 32'h0, 32'h300, 32'h5, 0, 0, 32'h300, 0, 0, 1, 1), "postFlushAdd");

    // Asynchronous reset in the middle of a multiply
    repeat (2) @(negedge clk);
    driveOp(mk(OP_MUL, 32'h1234, 32'h10, 32'h0, 32'h700, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midRst.outValid", bus.out_valid, 1'b0);
    checkOutput("midRst.result", bus.out_result, 32'h0);
    checkOutput("midRst.target", bus.br_target, 32'h0);
    checkOutput("midRst.inReady", bus.in_ready, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("midRst.inReadyAfter", bus.in_ready, 1'b1);
    watchNoValid("midRst.neverValid", 25);
    runVec(mk(6'h3F, 32'hDEAD, 32'hBEEF, 32'h1, 32'h800, 32'h0, 0, 0, 32'h800, 0, 1, 1, 1), "postRstIllegal");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL globalTimeout: got simulation still running, expected finish");
    $fatal(1, "[TB] timeout");
  end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, handshaked execute-stage ALU that takes over from the single-cycle EX-stage ALU.
- Keeps the 6-bit opcode map (arithmetic/logic, LDW/STW address generation, BZ/BEQ/JR resolution) and fixes the arithmetic to true two's complement with wrap and overflow flags.
- Adds an iterative multi-cycle signed multiplier, valid/ready flow control on both sides, pipeline flush and illegal-opcode reporting.
- Sits between decode/register-read and the MEM stage.

Parameters:
- DATA_W, 32, operand/result width (even, >=8)
- MUL_STEP, 2, multiplier bits retired per cycle (1, 2 or 4; must divide DATA_W)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of in-flight op and output register
- in_valid  in  1  operation offered
- in_ready  out  1  ALU can accept this cycle
- op  in  6  opcode
- rs_val  in  DATA_W  source A
- rt_val  in  DATA_W  source B
- imm  in  DATA_W  sign-extended immediate
- pc4  in  DATA_W  PC+4 of the instruction
- out_valid  out  1  result held
- out_ready  in  1  downstream accepts
- out_result  out  DATA_W  ALU result; LDW/STW effective address
- out_is_mem  out  1  op was LDW/STW
- br_taken  out  1  branch/jump redirects PC
- br_target  out  DATA_W  redirect address (pc4 when not taken)
- ovf  out  1  signed overflow (ADD/ADDI/SUB/SUBI/MUL/MULI only)
- illegal  out  1  opcode > 0x10

Behaviour:
- Reset (rst_n low, asynchronous): FSM to IDLE; all outputs 0 except in_ready (combinational, 1 once out of reset).
- Opcodes:
  - 00 ADD rs+rt; 01 ADDI rs+imm; 02 SUB rs-rt; 03 SUBI rs-imm
  - 04 MUL rs*rt; 05 MULI rs*imm
  - 06/07 OR, 08/09 AND, 0A/0B XOR (reg / imm)
  - 0C LDW, 0D STW: out_result = rs+imm, out_is_mem = 1
  - 0E BZ: taken if rs==0
  - 0F BEQ: taken if rs==rt
  - 10 JR: taken, target = rs
  - BZ/BEQ target when taken = pc4+imm
  - Illegal opcode: out_result 0, illegal 1, br_taken 0.
- Arithmetic:
  - All results modulo 2^DATA_W, signed two's complement.
  - ADD ovf: operand signs equal and result sign differs. SUB ovf: operand signs differ and result sign differs from rs.
  - MUL returns low DATA_W bits of the full 2*DATA_W signed product; ovf = product not representable in DATA_W signed bits.
- Handshake:
  - Accept occurs when in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
  - Output register is stable while out_valid && !out_ready.
  - out_valid drops the cycle after a transfer unless a new result loads in the same cycle.
- FSM states IDLE, MUL, HOLD:
  - IDLE, non-MUL accepted: result registered, out_valid next edge (latency 1).
  - IDLE, MUL/MULI accepted: go to MUL. Counter runs DATA_W/MUL_STEP cycles (radix-2^MUL_STEP shift-add on magnitudes, sign applied at end). in_ready = 0 throughout.
  - MUL, counter done: load output register and return to IDLE; out_valid rises DATA_W/MUL_STEP+1 edges after accept. If the output register is still occupied (not drained), go to HOLD.
  - HOLD: load when the output register frees, then return to IDLE.
- Flush: at the next edge clears out_valid, aborts MUL/HOLD to IDLE, and drops any accept attempted that cycle. Flush has priority over every other event.
- Reset mid-multiply: immediate return to IDLE; partial product discarded.
- Branch outputs are valid only with out_valid. br_target = pc4 when not taken.

Decomposition:
- Package alu_pkg:
  - opcode enum (OP_ADD..OP_JR)
  - FSM state enum
  - function is_mem_op
  - function is_imm_op (operand-B select)
- Sub-module alu_mul_iter (parametrised DATA_W, MUL_STEP; start/done handshake; product[2*DATA_W-1:0]).

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 -> out_result 0x80000000, ovf 1, one cycle after accept; SUBI 5 - imm 0xFFFFFFFD (-3) -> 8, ovf 0.
- MUL 0xFFFFFFFA (-6) * 7 with MUL_STEP=2 -> out_result 0xFFFFFFD6 (-42), ovf 0, out_valid 17 edges after accept, in_ready 0 in between; MUL 0x00010000*0x00010000 -> 0, ovf 1.
- BEQ rs=rt=9, pc4=0x100, imm=0x10 -> br_taken 1, br_target 0x110; BZ rs=1 -> br_taken 0, br_target 0x100; JR rs=0x400 -> target 0x400.
- out_ready held 0 for 5 cycles after LDW rs=0x1000 imm=0xFFFFFFFC -> out_result 0x00000FFC stable, out_is_mem 1, in_ready 0; a MUL issued before stall completes into HOLD, then emits on drain.
- flush asserted in 3rd MUL cycle -> out_valid never rises for that op; in_ready 1 the following cycle; next ADD 2+3 -> 5.
- rst_n pulsed low mid-MUL (asynchronous, between edges) -> outputs 0 immediately; op 0x3F -> illegal 1, out_result 0.
